// File: rtl/stepper_driver_multi_if.sv
// Bundle of control inputs and coil outputs for the stepper driver.
//   master : board side. Drives en, dir, mode, inc_n and dec_n; observes coils,
//            step_tick and period.
//   slave  : driver side. Receives the controls; produces coils, step_tick and period.
//   en        1 = drive coils and step, 0 = coils off with position held
//   dir       1 = forward, 0 = reverse
//   mode      0 = wave, 1 = full two-phase, 2/3 = half-step
//   inc_n     active-low button that lengthens the step period
//   dec_n     active-low button that shortens the step period
//   coils     registered coil drive pattern
//   step_tick one-cycle pulse on every step event
//   period    current divider period in clk cycles
interface stepper_driver_multi_if #(
    parameter int unsigned DIV_W = 32
);
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic             inc_n;
    logic             dec_n;
    logic [3:0]       coils;
    logic             step_tick;
    logic [DIV_W-1:0] period;

    modport master (
        output en, dir, mode, inc_n, dec_n,
        input  coils, step_tick, period
    );

    modport slave (
        input  en, dir, mode, inc_n, dec_n,
        output coils, step_tick, period
    );
endinterface

// File: rtl/stepper_driver_multi.sv
// Unipolar 4-coil stepper driver. It produces wave, full two-phase or half-step
// coil sequences, forward or reverse. A clock divider sets the step rate, and
// two debounced active-low buttons adjust the divider period at run time.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    stepper_driver_multi_if.slave. Carries the en/dir/mode/inc_n/dec_n
//          controls in and coils/step_tick/period out.
module stepper_driver_multi #(
    parameter int unsigned DIV_W        = 32,
    parameter int unsigned DIV_INIT     = 200_000,
    parameter int unsigned DIV_MIN      = 50_000,
    parameter int unsigned DIV_MAX      = 2_500_000,
    parameter int unsigned DIV_STEP     = 25_000,
    parameter int unsigned DEBOUNCE_CYC = 5_000_000
) (
    input logic                   clk,
    input logic                   rst_n,
    stepper_driver_multi_if.slave bus
);

    localparam int unsigned DBC_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DIV_W-1:0] INIT_C = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] MIN_C  = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] MAX_C  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] STEP_C = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_INC   = 2'd1,
        DB_DEC   = 2'd2,
        WAIT_REL = 2'd3
    } btn_state_t;

    btn_state_t       state_q, state_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       coils_q, coils_d;
    logic [1:0]       inc_sync_q, dec_sync_q;
    logic             inc_p, dec_p;

    // Saturating period updates. Comparing the distance to the limit avoids
    // any wrap of the DIV_W-bit arithmetic.
    function automatic logic [DIV_W-1:0] sat_inc(input logic [DIV_W-1:0] p);
        if ((MAX_C - p) <= STEP_C) return MAX_C;
        return p + STEP_C;
    endfunction

    function automatic logic [DIV_W-1:0] sat_dec(input logic [DIV_W-1:0] p);
        if ((p - MIN_C) <= STEP_C) return MIN_C;
        return p - STEP_C;
    endfunction

    function automatic logic [3:0] coil_pattern(input logic [2:0] ph);
        case (ph)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    // Wave lives on even indices and full-step on odd ones. When the phase
    // parity does not match the mode (just after a mode change), a single
    // step of 1 realigns it. The 3-bit sum wraps modulo 8 by itself.
    function automatic logic [2:0] next_phase(input logic [2:0] ph,
                                              input logic       fwd,
                                              input logic [1:0] md);
        logic [2:0] delta;
        if (md[1] || (ph[0] != md[0])) delta = 3'd1;
        else                           delta = 3'd2;
        return fwd ? (ph + delta) : (ph - delta);
    endfunction

    // Buttons are synchronised and converted to active-high "pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_sync_q <= 2'b00;
            dec_sync_q <= 2'b00;
        end else begin
            inc_sync_q <= {inc_sync_q[0], ~bus.inc_n};
            dec_sync_q <= {dec_sync_q[0], ~bus.dec_n};
        end
    end

    assign inc_p = inc_sync_q[1];
    assign dec_p = dec_sync_q[1];

    // Button FSM: debounce one button, apply one period change, wait for release.
    always_comb begin
        state_d  = state_q;
        dbc_d    = dbc_q;
        period_d = period_q;
        case (state_q)
            IDLE: begin
                if (inc_p && !dec_p) begin
                    state_d = DB_INC;
                    dbc_d   = '0;
                end else if (dec_p && !inc_p) begin
                    state_d = DB_DEC;
                    dbc_d   = '0;
                end
            end
            DB_INC: begin
                if (!inc_p || dec_p) begin
                    state_d = IDLE;
                end else if (dbc_q == DBC_LAST) begin
                    period_d = sat_inc(period_q);
                    state_d  = WAIT_REL;
                end else begin
                    dbc_d = dbc_q + 1'b1;
                end
            end
            DB_DEC: begin
                if (!dec_p || inc_p) begin
                    state_d = IDLE;
                end else if (dbc_q == DBC_LAST) begin
                    period_d = sat_dec(period_q);
                    state_d  = WAIT_REL;
                end else begin
                    dbc_d = dbc_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!inc_p && !dec_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider. Using >= rather than == means that when a period shrinks below
    // the running count, the count still terminates on the next cycle.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (bus.en) begin
            if (cnt_q >= (period_q - ONE_C)) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Phase advances on the tick. Coils follow the phase one cycle later.
    always_comb begin
        phase_d = phase_q;
        if (tick_q) phase_d = next_phase(phase_q, bus.dir, bus.mode);
        coils_d = bus.en ? coil_pattern(phase_q) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dbc_q    <= '0;
            period_q <= INIT_C;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            phase_q  <= 3'd0;
            coils_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            dbc_q    <= dbc_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            coils_q  <= coils_d;
        end
    end

    assign bus.coils     = coils_q;
    assign bus.step_tick = tick_q;
    assign bus.period    = period_q;

endmodule

// File: tb/tb_stepper_driver_multi.sv
module tb_stepper_driver_multi;

    localparam int unsigned DIV_W = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    stepper_driver_multi_if #(.DIV_W(DIV_W)) bus();

    stepper_driver_multi #(
        .DIV_W       (DIV_W),
        .DIV_INIT    (10),
        .DIV_MIN     (4),
        .DIV_MAX     (16),
        .DIV_STEP    (4),
        .DEBOUNCE_CYC(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] mode;
        logic       dir;
        logic [3:0] coils;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Wait (bounded) for a negedge at which step_tick is high.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.step_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tick_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no step_tick expected one within 40 cycles", name);
    endtask

    task automatic press(input bit use_inc, input bit use_dec, input int n);
        @(negedge clk);
        if (use_inc) bus.inc_n = 1'b0;
        if (use_dec) bus.dec_n = 1'b0;
        repeat (n) @(negedge clk);
        bus.inc_n = 1'b1;
        bus.dec_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int prev;
        int c0;

        total = 0;
        bad   = 0;

        // Half forward through a full wrap, then wave reverse from phase 0,
        // then a switch to full (one realign step), then full forward.
        vecs[0]  = '{2'd2, 1'b1, 4'b0011};
        vecs[1]  = '{2'd2, 1'b1, 4'b0010};
        vecs[2]  = '{2'd2, 1'b1, 4'b0110};
        vecs[3]  = '{2'd2, 1'b1, 4'b0100};
        vecs[4]  = '{2'd2, 1'b1, 4'b1100};
        vecs[5]  = '{2'd2, 1'b1, 4'b1000};
        vecs[6]  = '{2'd2, 1'b1, 4'b1001};
        vecs[7]  = '{2'd2, 1'b1, 4'b0001};
        vecs[8]  = '{2'd0, 1'b0, 4'b1000};
        vecs[9]  = '{2'd0, 1'b0, 4'b0100};
        vecs[10] = '{2'd0, 1'b0, 4'b0010};
        vecs[11] = '{2'd0, 1'b0, 4'b0001};
        vecs[12] = '{2'd1, 1'b0, 4'b1001};
        vecs[13] = '{2'd1, 1'b0, 4'b1100};
        vecs[14] = '{2'd1, 1'b0, 4'b0110};
        vecs[15] = '{2'd1, 1'b1, 4'b1100};
        vecs[16] = '{2'd1, 1'b1, 4'b1001};
        vecs[17] = '{2'd1, 1'b1, 4'b0011};

        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.dir   = 1'b1;
        bus.mode  = 2'd2;
        bus.inc_n = 1'b1;
        bus.dec_n = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_coils", 32'(bus.coils), 32'h0);
        chk("reset_tick", 32'(bus.step_tick), 32'h0);
        chk("reset_period", bus.period, 32'd10);
        #2 rst_n = 1'b1;

        prev = 0;
        for (int i = 0; i < 18; i++) begin
            bus.mode = vecs[i].mode;
            bus.dir  = vecs[i].dir;
            wait_tick(ok);
            if (!ok) begin
                tick_timeout($sformatf("vec%0d_tick", i));
            end else begin
                if (i > 0) chk($sformatf("vec%0d_gap", i), 32'(cyc - prev), 32'd10);
                prev = cyc;
                @(negedge clk);
                chk($sformatf("vec%0d_tick_width", i), 32'(bus.step_tick), 32'h0);
                @(negedge clk);
                chk($sformatf("vec%0d_coils", i), 32'(bus.coils), 32'(vecs[i].coils));
            end
        end

        // Disable mid-run: coils off next cycle, no ticks, phase (1) held.
        bus.en = 1'b0;
        @(negedge clk);
        chk("en_off_coils", 32'(bus.coils), 32'h0);
        ok = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.step_tick !== 1'b0 || bus.coils !== 4'b0000) ok = 1'b1;
        end
        chk("en_off_quiet", 32'(ok), 32'h0);
        bus.en = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("en_on_coils", 32'(bus.coils), 32'b0011);
        wait_tick(ok);
        if (!ok) begin
            tick_timeout("en_on_tick");
        end else begin
            chk("en_on_first_tick", 32'(cyc - c0), 32'd10);
            repeat (2) @(negedge clk);
            chk("en_on_step", 32'(bus.coils), 32'b0110);
        end

        // Increase presses: short one rejected, then saturate at 16.
        press(1'b1, 1'b0, 5);
        chk("inc_short", bus.period, 32'd10);
        press(1'b1, 1'b0, 20);
        chk("inc_1", bus.period, 32'd14);
        press(1'b1, 1'b0, 20);
        chk("inc_2_sat", bus.period, 32'd16);
        press(1'b1, 1'b0, 20);
        chk("inc_3_sat", bus.period, 32'd16);

        // Reset while debouncing an inc press and mid-count.
        @(negedge clk);
        bus.inc_n = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_coils", 32'(bus.coils), 32'h0);
        chk("rst_mid_tick", 32'(bus.step_tick), 32'h0);
        chk("rst_mid_period", bus.period, 32'd10);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_phase0_coils", 32'(bus.coils), 32'b0001);
        repeat (20) @(negedge clk);
        bus.inc_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_held_new_press", bus.period, 32'd14);

        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_period", bus.period, 32'd10);

        // Decrease presses down to the lower limit; both together do nothing.
        press(1'b0, 1'b1, 20);
        chk("dec_1", bus.period, 32'd6);
        press(1'b1, 1'b1, 20);
        chk("both_pressed", bus.period, 32'd6);
        press(1'b0, 1'b1, 20);
        chk("dec_2_sat", bus.period, 32'd4);
        press(1'b0, 1'b1, 20);
        chk("dec_3_sat", bus.period, 32'd4);

        // Steps still occur at the shortest period.
        wait_tick(ok);
        if (!ok) begin
            tick_timeout("min_period_tick");
        end else begin
            prev = cyc;
            wait_tick(ok);
            if (!ok) tick_timeout("min_period_tick2");
            else chk("min_period_gap", 32'(cyc - prev), 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
